program_counter: RTL and testbench
==================================

# program_counter

8-bit program counter with a small hardware return-address stack. It sits immediately upstream of the instruction-fetch path: its `pc` output addresses program memory, and the fetched instruction is latched into the clock-enabled flip-flop registers that follow. It advances, jumps, branches, calls and returns under a 3-bit opcode from the control unit, one operation per enabled clock edge.

## Interface
- `WIDTH`, 8, address width of `pc`, `target` and each stack entry.
- `STACK_DEPTH`, 4, number of return-address entries; must be a power of two, 2..16.

- `clock`  input  1  rising-edge clock.
- `clear`  input  1  synchronous, active-high reset; sampled on the rising edge of `clock`.
- `enable`  input  1  clock enable; when low, all state holds regardless of `op`.
- `op`  input  3  operation select: 0 HOLD, 1 INC, 2 JUMP, 3 CALL, 4 RET, 5 BRANCH; 6 and 7 behave as HOLD.
- `target`  input  WIDTH  absolute address for JUMP/CALL; two's-complement offset for BRANCH.
- `pc`  output  WIDTH  current program address.
- `stack_full`  output  1  high when the stack holds STACK_DEPTH entries.
- `stack_empty`  output  1  high when the stack holds 0 entries.
- `fault`  output  1  sticky flag for stack overflow or underflow.

## Operation
- Priority on each rising edge: `clear`, then `enable` low (hold), then `op`.
- HOLD: no state change.
- INC: `pc <= pc + 1`, modulo 2^WIDTH (0xFF wraps to 0x00).
- JUMP: `pc <= target`.
- BRANCH: `pc <= pc + sign_extend(target)`, modulo 2^WIDTH. Example: pc 0x10 with target 0xFE gives 0x0E; pc 0xFF with target 0x01 gives 0x00.
- CALL when not full: push `pc + 1` (wrapped), `pc <= target`, count + 1.
- CALL when full: no push, `pc` unchanged, `fault <= 1`.
- RET when not empty: `pc <= top entry`, pop, count − 1.
- RET when empty: `pc` unchanged, `fault <= 1`.
- Stack is LIFO and implemented as an entry array plus a count register (0..STACK_DEPTH).
  - Push writes entry[count]; pop reads entry[count−1].
  - Popped entries are not cleared.
- `fault` is cleared only by `clear`. A fault has no effect on later operations; a valid CALL or RET after a fault executes normally.

## Timing
- Every output is a register, or a decode of the count register; there is no combinational path from any input to any output.
- Latency is one cycle: `op` and `target` are sampled at edge N, and the new `pc`, flags and stack state are visible after edge N.
- `stack_full` and `stack_empty` update on the same edge as the push or pop that changes the count.
- Reset values: `pc` = 0, count = 0, `stack_empty` = 1, `stack_full` = 0, `fault` = 0. Stack entry contents are don't-care.
- `clear` mid-sequence (for example, during a run of CALLs) takes effect at that edge; the op presented in the same cycle is discarded.
- `clear` high with `enable` low still resets.
- `enable` low for any number of cycles freezes `pc`, count and `fault` exactly.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `PC_HOLD`, `PC_INC`, `PC_JUMP`, `PC_CALL`, `PC_RET`, `PC_BRANCH`;
  - the default `WIDTH` constant, shared with the fetch and register stages.
- Sub-module `register_ce`: a WIDTH-bit register with synchronous clear and clock enable.
  - Used for `pc`.
  - Used for each stack entry: write-enable = push and index match.
- The count register, flags and next-pc multiplexer live in `program_counter`.

## Test plan
- Reset then INC: `clear` for 1 cycle, then 3 INC cycles → pc 0x00, 0x01, 0x02, 0x03; `stack_empty` = 1, `fault` = 0.
- Wrap and branch:
  - JUMP 0xFE, then INC, INC → pc 0xFE, 0xFF, 0x00.
  - BRANCH 0xFC from 0x00 → pc 0xFC.
  - BRANCH 0x05 from 0xFC → pc 0x01.
- Nested calls:
  - From pc 0x10: CALL 0x40, then CALL 0x80 → stack [0x11, 0x41], pc 0x80.
  - RET → pc 0x41; RET → pc 0x11; `stack_empty` = 1.
- Overflow: 4 CALLs → `stack_full` = 1. A 5th CALL 0x99 → pc unchanged, `fault` = 1. Then 4 RETs return the correct addresses in reverse order; `fault` stays 1.
- Underflow and enable:
  - RET on empty → pc unchanged, `fault` = 1.
  - `enable` = 0 with INC for 5 cycles → pc unchanged.
- Reset mid-operation: after 2 CALLs, assert `clear` together with op CALL → pc 0, `stack_empty` = 1, `fault` = 0, no push.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch front end: the default address width used
// by the program counter, fetch and register stages, and the program-counter
// opcode encodings driven by the control unit.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Default address / data width shared by the fetch path stages.
    localparam int PC_WIDTH = 8;

    // Program-counter operation select. Encodings 6 and 7 are unused and
    // behave as HOLD.
    localparam logic [2:0] PC_HOLD   = 3'd0;
    localparam logic [2:0] PC_INC    = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_CALL   = 3'd3;
    localparam logic [2:0] PC_RET    = 3'd4;
    localparam logic [2:0] PC_BRANCH = 3'd5;

endpackage

// File: rtl/register_ce.sv
// ----------------------------------------------------------------------------
// register_ce
// WIDTH-bit register with synchronous active-high clear and clock enable.
// Clear has priority over enable.
//
// Ports:
//   clk_i   rising-edge clock
//   srst_i  synchronous clear, loads zero
//   en_i    clock enable; register holds when low
//   d_i     next value
//   q_o     registered value
// ----------------------------------------------------------------------------
module register_ce #(
    parameter int WIDTH = cpu_pkg::PC_WIDTH
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/program_counter.sv
// ----------------------------------------------------------------------------
// program_counter
// Program counter with a small LIFO return-address stack. One operation per
// enabled clock edge: HOLD, INC, JUMP, CALL, RET, BRANCH (opcodes 6/7 hold).
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset (highest priority)
//   enable       clock enable; all state holds when low
//   op           operation select (cpu_pkg::PC_*)
//   target       absolute address (JUMP/CALL) or signed offset (BRANCH)
//   pc           current program address (registered)
//   stack_full   stack holds STACK_DEPTH entries (decode of count)
//   stack_empty  stack holds no entries (decode of count)
//   fault        sticky overflow/underflow flag, cleared only by clear
// ----------------------------------------------------------------------------
module program_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH       = PC_WIDTH,
    parameter int STACK_DEPTH = 4          // power of two, 2..16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             fault
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fault_q;
    logic             fault_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);
    assign pc_plus1 = pc_q + 1'b1;

    // count never exceeds STACK_DEPTH-1 when a push happens and is never zero
    // when a pop happens, so truncating to the index width is exact.
    assign push_idx = IDX_W'(cnt_q);
    assign pop_idx  = IDX_W'(cnt_q - 1'b1);

    assign push = enable && (op == PC_CALL) && !full;
    assign pop  = enable && (op == PC_RET)  && !empty;

    // Next-pc multiplexer. The pc register is enabled by `enable` alone;
    // HOLD and failed CALL/RET simply reload the current value.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_INC:    pc_d = pc_plus1;
            PC_JUMP:   pc_d = target;
            PC_CALL:   pc_d = full  ? pc_q : target;
            PC_RET:    pc_d = empty ? pc_q : stack_q[pop_idx];
            // Sign extension to WIDTH bits is the identity, so a plain
            // modular add of the offset gives pc + sign_extend(target).
            PC_BRANCH: pc_d = pc_q + target;
            default:   pc_d = pc_q;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (push) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (enable && (((op == PC_CALL) && full) || ((op == PC_RET) && empty))) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    register_ce #(.WIDTH(WIDTH)) u_pc_reg (
        .clk_i  (clock),
        .srst_i (clear),
        .en_i   (enable),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // Return-address entries; popped entries are left as-is.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            register_ce #(.WIDTH(WIDTH)) u_entry (
                .clk_i  (clock),
                .srst_i (clear),
                .en_i   (push && (push_idx == IDX_W'(gi))),
                .d_i    (pc_plus1),
                .q_o    (stack_q[gi])
            );
        end
    endgenerate

    assign pc          = pc_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign fault       = fault_q;

endmodule

// File: tb/tb_program_counter.sv
// ----------------------------------------------------------------------------
// tb_program_counter
// Directed tests for program_counter with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that applied the operation.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_counter;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] op = PC_HOLD;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic       stack_full;
    logic       stack_empty;
    logic       fault;

    int vec_count  = 0;
    int miss_count = 0;

    program_counter #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clock       (clock),
        .clear       (clear),
        .enable      (enable),
        .op          (op),
        .target      (target),
        .pc          (pc),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    // Apply one operation for exactly one rising edge, then settle.
    task automatic drive(input logic clr, input logic en, input logic [2:0] o, input logic [7:0] t);
        @(negedge clock);
        clear  = clr;
        enable = en;
        op     = o;
        target = t;
        @(posedge clock);
        #1;
        $display("op clr=%0b en=%0b op=%0d tgt=%h -> pc=%h full=%0b empty=%0b fault=%0b",
                 clr, en, o, t, pc, stack_full, stack_empty, fault);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, PC_HOLD, 8'h00);
        vec_count++; if (pc !== 8'h00) begin miss_count++; $display("FAIL reset_pc: got %h want 00", pc); end
        vec_count++; if (stack_empty !== 1'b1 || stack_full !== 1'b0 || fault !== 1'b0) begin
            miss_count++; $display("FAIL reset_flags: got e=%0b f=%0b flt=%0b want 1 0 0", stack_empty, stack_full, fault); end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, PC_INC, 8'h00);
            vec_count++; if (pc !== 8'(i)) begin miss_count++; $display("FAIL inc%0d: got %h want %h", i, pc, 8'(i)); end
        end
        vec_count++; if (stack_empty !== 1'b1 || fault !== 1'b0) begin
            miss_count++; $display("FAIL inc_flags: got e=%0b flt=%0b want 1 0", stack_empty, fault); end
    endtask

    task automatic test_wrap_branch;
        drive(1'b0, 1'b1, PC_JUMP, 8'hFE);
        vec_count++; if (pc !== 8'hFE) begin miss_count++; $display("FAIL jump_fe: got %h want fe", pc); end
        drive(1'b0, 1'b1, PC_INC, 8'h00);
        vec_count++; if (pc !== 8'hFF) begin miss_count++; $display("FAIL inc_ff: got %h want ff", pc); end
        drive(1'b0, 1'b1, PC_INC, 8'h00);
        vec_count++; if (pc !== 8'h00) begin miss_count++; $display("FAIL inc_wrap: got %h want 00", pc); end
        drive(1'b0, 1'b1, PC_BRANCH, 8'hFC);
        vec_count++; if (pc !== 8'hFC) begin miss_count++; $display("FAIL br_back: got %h want fc", pc); end
        drive(1'b0, 1'b1, PC_BRANCH, 8'h05);
        vec_count++; if (pc !== 8'h01) begin miss_count++; $display("FAIL br_fwd_wrap: got %h want 01", pc); end
        drive(1'b0, 1'b1, PC_JUMP, 8'h10);
        drive(1'b0, 1'b1, PC_BRANCH, 8'hFE);
        vec_count++; if (pc !== 8'h0E) begin miss_count++; $display("FAIL br_minus2: got %h want 0e", pc); end
        drive(1'b0, 1'b1, 3'd7, 8'h55);
        vec_count++; if (pc !== 8'h0E) begin miss_count++; $display("FAIL op7_hold: got %h want 0e", pc); end
    endtask

    task automatic test_nested_calls;
        drive(1'b0, 1'b1, PC_JUMP, 8'h10);
        drive(1'b0, 1'b1, PC_CALL, 8'h40);
        vec_count++; if (pc !== 8'h40 || stack_empty !== 1'b0) begin
            miss_count++; $display("FAIL call1: got pc=%h e=%0b want 40 0", pc, stack_empty); end
        drive(1'b0, 1'b1, PC_CALL, 8'h80);
        vec_count++; if (pc !== 8'h80) begin miss_count++; $display("FAIL call2: got %h want 80", pc); end
        drive(1'b0, 1'b1, PC_RET, 8'h00);
        vec_count++; if (pc !== 8'h41) begin miss_count++; $display("FAIL ret1: got %h want 41", pc); end
        drive(1'b0, 1'b1, PC_RET, 8'h00);
        vec_count++; if (pc !== 8'h11 || stack_empty !== 1'b1 || fault !== 1'b0) begin
            miss_count++; $display("FAIL ret2: got pc=%h e=%0b flt=%0b want 11 1 0", pc, stack_empty, fault); end
    endtask

    task automatic test_overflow;
        logic [7:0] tgts [4];
        logic [7:0] rets [4];
        tgts = '{8'h20, 8'h30, 8'h40, 8'h50};
        rets = '{8'h41, 8'h31, 8'h21, 8'h12};   // pc 0x11 at entry
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, PC_CALL, tgts[i]);
            vec_count++; if (pc !== tgts[i] || stack_full !== (i == 3)) begin
                miss_count++; $display("FAIL ovf_call%0d: got pc=%h full=%0b want %h %0b", i, pc, stack_full, tgts[i], i == 3); end
        end
        drive(1'b0, 1'b1, PC_CALL, 8'h99);
        vec_count++; if (pc !== 8'h50 || fault !== 1'b1 || stack_full !== 1'b1) begin
            miss_count++; $display("FAIL ovf_call5: got pc=%h flt=%0b full=%0b want 50 1 1", pc, fault, stack_full); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, PC_RET, 8'h00);
            vec_count++; if (pc !== rets[i] || fault !== 1'b1 || stack_full !== 1'b0 || stack_empty !== (i == 3)) begin
                miss_count++; $display("FAIL ovf_ret%0d: got pc=%h flt=%0b full=%0b e=%0b want %h 1 0 %0b",
                                       i, pc, fault, stack_full, stack_empty, rets[i], i == 3); end
        end
    endtask

    task automatic test_underflow_enable;
        drive(1'b1, 1'b1, PC_HOLD, 8'h00);
        vec_count++; if (fault !== 1'b0 || pc !== 8'h00) begin
            miss_count++; $display("FAIL clr_fault: got pc=%h flt=%0b want 00 0", pc, fault); end
        drive(1'b0, 1'b1, PC_JUMP, 8'h33);
        drive(1'b0, 1'b1, PC_RET, 8'h00);
        vec_count++; if (pc !== 8'h33 || fault !== 1'b1 || stack_empty !== 1'b1) begin
            miss_count++; $display("FAIL unf_ret: got pc=%h flt=%0b e=%0b want 33 1 1", pc, fault, stack_empty); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, PC_INC, 8'h00);
            vec_count++; if (pc !== 8'h33 || fault !== 1'b1) begin
                miss_count++; $display("FAIL en_hold%0d: got pc=%h flt=%0b want 33 1", i, pc, fault); end
        end
        drive(1'b0, 1'b0, PC_CALL, 8'h77);
        vec_count++; if (pc !== 8'h33 || stack_empty !== 1'b1) begin
            miss_count++; $display("FAIL en_call: got pc=%h e=%0b want 33 1", pc, stack_empty); end
        drive(1'b0, 1'b1, PC_CALL, 8'h60);
        vec_count++; if (pc !== 8'h60 || stack_empty !== 1'b0) begin
            miss_count++; $display("FAIL post_fault_call: got pc=%h e=%0b want 60 0", pc, stack_empty); end
        drive(1'b0, 1'b1, PC_RET, 8'h00);
        vec_count++; if (pc !== 8'h34 || fault !== 1'b1) begin
            miss_count++; $display("FAIL post_fault_ret: got pc=%h flt=%0b want 34 1", pc, fault); end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 1'b1, PC_HOLD, 8'h00);
        drive(1'b0, 1'b1, PC_CALL, 8'h70);
        drive(1'b0, 1'b1, PC_CALL, 8'h72);
        vec_count++; if (pc !== 8'h72) begin miss_count++; $display("FAIL mid_calls: got %h want 72", pc); end
        drive(1'b1, 1'b1, PC_CALL, 8'h90);
        vec_count++; if (pc !== 8'h00 || stack_empty !== 1'b1 || stack_full !== 1'b0 || fault !== 1'b0) begin
            miss_count++; $display("FAIL mid_clear: got pc=%h e=%0b full=%0b flt=%0b want 00 1 0 0",
                                   pc, stack_empty, stack_full, fault); end
        drive(1'b0, 1'b1, PC_RET, 8'h00);
        vec_count++; if (pc !== 8'h00 || fault !== 1'b1) begin
            miss_count++; $display("FAIL mid_nopush: got pc=%h flt=%0b want 00 1", pc, fault); end
        drive(1'b0, 1'b1, PC_JUMP, 8'h44);
        drive(1'b1, 1'b0, PC_INC, 8'h00);
        vec_count++; if (pc !== 8'h00 || fault !== 1'b0) begin
            miss_count++; $display("FAIL clr_no_en: got pc=%h flt=%0b want 00 0", pc, fault); end
    endtask

    initial begin
        test_reset();
        test_wrap_branch();
        test_nested_calls();
        test_overflow();
        test_underflow_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no summary want summary");
        $fatal(1, "timeout");
    end

endmodule
